mem_bus_controller: RTL and testbench
=====================================

Name: mem_bus_controller

Overview:
- Sits directly upstream of the word-addressed synchronous memory and is its only master.
- Arbitrates two CPU-side requesters: the instruction fetch port (read-only) and the load/store data port (read/write).
- Converts their byte addresses and req/ack handshakes into single-cycle memory commands (addr, wdata, wren, rren, E).
- Waits out the memory's registered read latency, then returns the read word with a one-cycle ack.

Parameters:
- MEM_WORDS, 4096: number of 32-bit words in the memory. A word index >= MEM_WORDS is an error.
- RD_LATENCY, 1: cycles from the command edge until mem_rdata is valid. Legal range 1..7.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- i_req  in  1  instruction read request; level, held until i_ack.
- i_addr  in  32  instruction byte address.
- i_ack  out  1  one-cycle completion pulse for the instruction port.
- i_rdata  out  32  instruction word; valid while i_ack=1.
- i_err  out  1  error flag; valid while i_ack=1.
- d_req  in  1  data request; level, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle completion pulse for the data port.
- d_rdata  out  32  load data; valid while d_ack=1.
- d_err  out  1  error flag; valid while d_ack=1.
- mem_addr  out  30  memory word address.
- mem_wdata  out  32  memory write data.
- mem_wren  out  1  memory write enable.
- mem_rren  out  1  memory read enable.
- mem_E  out  1  memory access enable.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; every output 0, including mem_addr and mem_wdata; rdata registers 0; last_grant=INSTR.
  - Reset mid-transaction aborts it. No ack is produced and no memory command completes after reset asserts.
- All outputs are registered; nothing is combinationally derived from the req inputs.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - No request pending: stay in IDLE.
  - Grant when i_req or d_req is high. Only one requesting: grant it.
  - Both requesting: grant the port opposite last_grant (round-robin). Update last_grant on every grant.
  - On grant, latch addr, we (instruction port: we=0), and wdata.
  - Error check uses the latched address: err if addr[1:0]!=0, or if addr[31:2] >= MEM_WORDS.
  - Error: go to RESP with err=1 and rdata=0. No mem_E pulse is issued.
  - No error: go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_E=1; mem_addr=addr[31:2]; mem_wren=we; mem_rren=~we; mem_wdata=latched wdata.
  - Write: next state RESP. Read: next state WAIT.
  - mem_E, mem_wren and mem_rren are 0 in every other state. mem_addr and mem_wdata hold their last value.
- WAIT:
  - Counter runs RD_LATENCY cycles.
  - On the final WAIT cycle, capture mem_rdata into the granted port's rdata register.
  - Then go to RESP.
- RESP (1 cycle):
  - Assert the granted port's ack; err as computed. The other port's ack stays 0.
  - Next state IDLE.
- Latency, request sampled in IDLE at cycle 0:
  - Read ack at cycle 2+RD_LATENCY (cycle 3 by default).
  - Write ack at cycle 2.
  - Error ack at cycle 1.
- Requester handshake:
  - A requester must deassert req in the cycle after ack, or present a new request.
  - In the IDLE cycle after RESP, a still-high req is a new request.
  - A req dropped before ack is a protocol violation; the transaction still completes.
- Data-port rdata holds its last value between acks. On a store ack, d_rdata is unchanged.
- Back-to-back throughput: one access per 3 cycles (write) or 4 cycles (read, RD_LATENCY=1).

Test Plan:
- Reset, then i_req=1 with i_addr=0x0000_0004.
  - mem_E/rren=1 with mem_addr=1 at cycle 1.
  - i_ack=1 at cycle 3 with i_rdata=memory word 1 (0x8c092040 under the default program image); i_err=0.
- d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEAD_BEEF.
  - mem_wren=1 and mem_addr=0x800 at cycle 1; d_ack at cycle 2.
  - A following load from 0x2000 returns 0xDEAD_BEEF.
- i_req and d_req asserted together and held continuously.
  - Grants alternate: data first, then instruction, then data.
  - i_ack and d_ack are never high in the same cycle.
- Error cases:
  - d_addr=0x0000_2002 → d_ack at cycle 1 with d_err=1, d_rdata=0, mem_E never asserted.
  - d_addr=0x0000_4000 (word 4096) → same response.
- Reset mid-read: rst pulled low during WAIT → all outputs 0 immediately, no i_ack. After release, a new request completes normally.
- RD_LATENCY=3: read ack at cycle 5; data captured from mem_rdata on the 3rd WAIT cycle.

Source files
------------

// File: rtl/mem_bus_controller_if.sv
// Bus bundle between the CPU-side requesters, the controller and the word-addressed memory.
// The controller is the master (sole driver of the memory command); the environment is the slave.
interface mem_bus_controller_if;
  // Instruction fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  // Load/store data port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  // Memory command and read-back
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wren;
  logic        mem_rren;
  logic        mem_E;
  logic [31:0] mem_rdata;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           mem_addr, mem_wdata, mem_wren, mem_rren, mem_E
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           mem_addr, mem_wdata, mem_wren, mem_rren, mem_E
  );
endinterface

// File: rtl/mem_bus_controller.sv
// Round-robin arbiter for instruction/data requesters in front of a synchronous word memory.
// Issues one-cycle memory commands, waits out the read latency and returns a one-cycle ack.
module mem_bus_controller #(
  parameter int MEM_WORDS  = 4096,
  parameter int RD_LATENCY = 1
) (
  input logic                  clk,
  input logic                  rst,
  mem_bus_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  typedef enum logic {GR_INSTR, GR_DATA} grant_t;

  localparam logic [31:0] LP_MEM_WORDS = 32'(MEM_WORDS);
  localparam logic [2:0]  LP_CNT_INIT  = 3'(RD_LATENCY - 1);

  state_t      r_state;
  grant_t      r_last_grant;
  logic        r_we;
  logic [2:0]  r_cnt;

  logic        r_i_ack;
  logic        r_i_err;
  logic [31:0] r_i_rdata;
  logic        r_d_ack;
  logic        r_d_err;
  logic [31:0] r_d_rdata;

  logic [29:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_wren;
  logic        r_mem_rren;
  logic        r_mem_E;

  logic        w_any_req;
  logic        w_pick_d;
  logic [31:0] w_addr;
  logic        w_we;
  logic [31:0] w_wdata;
  logic        w_err;

  // Data wins when it is the only requester or when instruction was granted last.
  assign w_any_req = bus.i_req | bus.d_req;
  assign w_pick_d  = bus.d_req & (~bus.i_req | (r_last_grant == GR_INSTR));
  assign w_addr    = w_pick_d ? bus.d_addr  : bus.i_addr;
  assign w_we      = w_pick_d & bus.d_we;
  assign w_wdata   = w_pick_d ? bus.d_wdata : '0;
  assign w_err     = (w_addr[1:0] != 2'b00) || ({2'b00, w_addr[31:2]} >= LP_MEM_WORDS);

  // The memory command registers double as the latched address/wdata of the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= GR_INSTR;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_i_ack      <= 1'b0;
      r_i_err      <= 1'b0;
      r_i_rdata    <= '0;
      r_d_ack      <= 1'b0;
      r_d_err      <= 1'b0;
      r_d_rdata    <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wren   <= 1'b0;
      r_mem_rren   <= 1'b0;
      r_mem_E      <= 1'b0;
    end else begin
      r_i_ack    <= 1'b0;
      r_i_err    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_d_err    <= 1'b0;
      r_mem_E    <= 1'b0;
      r_mem_wren <= 1'b0;
      r_mem_rren <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_last_grant <= w_pick_d ? GR_DATA : GR_INSTR;
            r_we         <= w_we;
            if (w_err) begin
              r_state <= RESP;
              if (w_pick_d) begin
                r_d_ack   <= 1'b1;
                r_d_err   <= 1'b1;
                r_d_rdata <= '0;
              end else begin
                r_i_ack   <= 1'b1;
                r_i_err   <= 1'b1;
                r_i_rdata <= '0;
              end
            end else begin
              r_state     <= ACCESS;
              r_mem_E     <= 1'b1;
              r_mem_addr  <= w_addr[31:2];
              r_mem_wdata <= w_wdata;
              r_mem_wren  <= w_we;
              r_mem_rren  <= ~w_we;
            end
          end
        end

        ACCESS: begin
          if (r_we) begin
            r_state <= RESP;
            if (r_last_grant == GR_DATA) r_d_ack <= 1'b1;
            else                         r_i_ack <= 1'b1;
          end else begin
            r_state <= WAIT;
            r_cnt   <= LP_CNT_INIT;
          end
        end

        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= RESP;
            if (r_last_grant == GR_DATA) begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= bus.mem_rdata;
            end else begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= bus.mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end

        RESP: r_state <= IDLE;

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.i_ack     = r_i_ack;
  assign bus.i_err     = r_i_err;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_ack     = r_d_ack;
  assign bus.d_err     = r_d_err;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wren  = r_mem_wren;
  assign bus.mem_rren  = r_mem_rren;
  assign bus.mem_E     = r_mem_E;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Scoreboard bench for mem_bus_controller: directed corner cases, then randomized
// concurrent traffic on both ports checked against a flat-array memory model.
module tb_mem_bus_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_controller_if b1 ();
  mem_bus_controller_if b3 ();

  mem_bus_controller #(.MEM_WORDS(4096), .RD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .bus(b1)
  );
  mem_bus_controller #(.MEM_WORDS(4096), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t qi[$];
  rsp_t qd[$];
  bit   seq[$];
  rsp_t ei, ed;

  logic [31:0] m1 [4096];
  logic [31:0] m3 [4096];
  logic [31:0] ref_mem [4096];
  logic [31:0] last_d;

  int unsigned cyc  = 0;
  int unsigned ecnt = 0;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int unsigned w);
    if (w == 1) return 32'h8c092040;
    return (w * 32'h9E3779B9) ^ 32'h5A5A0000 ^ w;
  endfunction

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
  endfunction

  // Memory models: outside the valid read cycle mem_rdata carries junk.
  always @(posedge clk) begin
    if (b1.mem_E && b1.mem_wren) m1[b1.mem_addr[11:0]] <= b1.mem_wdata;
    b1.mem_rdata <= (b1.mem_E && b1.mem_rren) ? m1[b1.mem_addr[11:0]] : $urandom();
  end

  logic [31:0] s1d, s2d;
  logic        s1v, s2v;
  always @(posedge clk) begin
    if (b3.mem_E && b3.mem_wren) m3[b3.mem_addr[11:0]] <= b3.mem_wdata;
    s1v <= b3.mem_E && b3.mem_rren;
    s1d <= m3[b3.mem_addr[11:0]];
    s2v <= s1v;
    s2d <= s1d;
    b3.mem_rdata <= s2v ? s2d : $urandom();
  end

  // Monitor: pops the per-port expectation whenever that port acks.
  always @(negedge clk) begin
    if (b1.mem_E) ecnt++;
    if (b1.i_ack || b1.d_ack) check("ack_exclusive", {31'b0, b1.i_ack & b1.d_ack}, 32'd0);
    if (b1.i_ack) begin
      seq.push_back(1'b0);
      check("i_ack_expected", {31'b0, qi.size() != 0}, 32'd1);
      if (qi.size() != 0) begin
        ei = qi.pop_front();
        check("i_rdata", b1.i_rdata, ei.rdata);
        check("i_err", {31'b0, b1.i_err}, {31'b0, ei.err});
      end
    end
    if (b1.d_ack) begin
      seq.push_back(1'b1);
      check("d_ack_expected", {31'b0, qd.size() != 0}, 32'd1);
      if (qd.size() != 0) begin
        ed = qd.pop_front();
        check("d_rdata", b1.d_rdata, ed.rdata);
        check("d_err", {31'b0, b1.d_err}, {31'b0, ed.err});
      end
    end
  end

  function automatic bit addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'd4096);
  endfunction

  task automatic issue_i(input logic [31:0] addr, input bit lat);
    rsp_t e;
    int unsigned c0, k;
    e.err   = addr_err(addr);
    e.rdata = e.err ? 32'd0 : ref_mem[addr[13:2]];
    qi.push_back(e);
    b1.i_addr = addr;
    b1.i_req  = 1'b1;
    c0 = cyc;
    @(negedge clk);
    if (lat) begin
      if (e.err) check("i_err_no_cmd", {31'b0, b1.mem_E}, 32'd0);
      else begin
        check("i_cmd_E", {31'b0, b1.mem_E}, 32'd1);
        check("i_cmd_rren", {31'b0, b1.mem_rren}, 32'd1);
        check("i_cmd_addr", {2'b0, b1.mem_addr}, {2'b0, addr[31:2]});
      end
    end
    k = 0;
    while (!b1.i_ack && k < 40) begin @(negedge clk); k++; end
    check("i_ack_seen", {31'b0, b1.i_ack}, 32'd1);
    if (lat) check("i_latency", cyc - c0, e.err ? 32'd1 : 32'd3);
    b1.i_req = 1'b0;
  endtask

  task automatic issue_d(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input bit lat);
    rsp_t e;
    int unsigned c0, e0, k;
    e.err = addr_err(addr);
    if (e.err) begin
      e.rdata = 32'd0;
      last_d  = 32'd0;
    end else if (we) begin
      ref_mem[addr[13:2]] = wdata;
      e.rdata = last_d;
    end else begin
      e.rdata = ref_mem[addr[13:2]];
      last_d  = e.rdata;
    end
    qd.push_back(e);
    b1.d_we    = we;
    b1.d_addr  = addr;
    b1.d_wdata = wdata;
    b1.d_req   = 1'b1;
    c0 = cyc;
    e0 = ecnt;
    @(negedge clk);
    if (lat) begin
      if (e.err) check("d_err_no_cmd", {31'b0, b1.mem_E}, 32'd0);
      else begin
        check("d_cmd_E", {31'b0, b1.mem_E}, 32'd1);
        check("d_cmd_wren", {31'b0, b1.mem_wren}, {31'b0, we});
        check("d_cmd_rren", {31'b0, b1.mem_rren}, {31'b0, ~we});
        check("d_cmd_addr", {2'b0, b1.mem_addr}, {2'b0, addr[31:2]});
        if (we) check("d_cmd_wdata", b1.mem_wdata, wdata);
      end
    end
    k = 0;
    while (!b1.d_ack && k < 40) begin @(negedge clk); k++; end
    check("d_ack_seen", {31'b0, b1.d_ack}, 32'd1);
    if (lat) begin
      check("d_latency", cyc - c0, e.err ? 32'd1 : (we ? 32'd2 : 32'd3));
      if (e.err) check("d_err_E_count", ecnt - e0, 32'd0);
    end
    b1.d_req = 1'b0;
  endtask

  task automatic l3_access(input bit dport, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int unsigned exp_lat,
                           input logic [31:0] exp_rdata);
    int unsigned c0, k;
    @(negedge clk);
    if (dport) begin
      b3.d_we = we; b3.d_addr = addr; b3.d_wdata = wdata; b3.d_req = 1'b1;
    end else begin
      b3.i_addr = addr; b3.i_req = 1'b1;
    end
    c0 = cyc;
    @(negedge clk);
    k = 0;
    while (!(b3.i_ack || b3.d_ack) && k < 40) begin @(negedge clk); k++; end
    check("l3_ack_port", {30'b0, b3.d_ack, b3.i_ack}, dport ? 32'd2 : 32'd1);
    check("l3_latency", cyc - c0, exp_lat);
    if (!we) check("l3_rdata", dport ? b3.d_rdata : b3.i_rdata, exp_rdata);
    b3.i_req = 1'b0;
    b3.d_req = 1'b0;
  endtask

  initial begin
    int unsigned k, nd, ni;
    for (int unsigned w = 0; w < 4096; w++) begin
      m1[w] = init_word(w); m3[w] = init_word(w); ref_mem[w] = init_word(w);
    end
    last_d = 32'd0;
    b1.i_req = 0; b1.i_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.i_req = 0; b3.i_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {25'b0, b1.i_ack, b1.d_ack, b1.i_err, b1.d_err, b1.mem_E, b1.mem_wren, b1.mem_rren}, 32'd0);
    check("reset_rdata", b1.i_rdata | b1.d_rdata, 32'd0);
    check("reset_mem_addr", {2'b0, b1.mem_addr}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    issue_i(32'h0000_0004, 1'b1);

    // Both held: data first (last grant was instruction), then instruction, then data.
    repeat (2) @(negedge clk);
    seq.delete();
    qd.push_back('{rdata: ref_mem[1024], err: 1'b0});
    qi.push_back('{rdata: ref_mem[8], err: 1'b0});
    qd.push_back('{rdata: ref_mem[1024], err: 1'b0});
    last_d = ref_mem[1024];
    b1.i_addr = 32'h20; b1.d_we = 1'b0; b1.d_addr = 32'h1000; b1.i_req = 1'b1; b1.d_req = 1'b1;
    nd = 0; ni = 0; k = 0;
    while (nd < 2 && k < 60) begin
      @(negedge clk); k++;
      if (b1.d_ack) nd++;
      if (b1.i_ack) ni++;
    end
    b1.i_req = 1'b0; b1.d_req = 1'b0;
    check("arb_d_acks", nd, 32'd2);
    check("arb_i_acks", ni, 32'd1);
    repeat (2) @(negedge clk);
    check("arb_order", {29'b0, seq[0], seq[1], seq[2]}, 32'b101);

    repeat (2) @(negedge clk);
    issue_d(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 1'b1);
    repeat (2) @(negedge clk);
    issue_d(1'b0, 32'h0000_2000, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    issue_d(1'b0, 32'h0000_2002, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    issue_d(1'b0, 32'h0000_4000, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    issue_d(1'b0, 32'h0000_3FFC, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    issue_d(1'b1, 32'h0000_4001, 32'h1234_5678, 1'b1);
    repeat (2) @(negedge clk);
    issue_i(32'h0000_0001, 1'b1);
    repeat (2) @(negedge clk);

    // Reset while the instruction read sits in WAIT.
    b1.i_addr = 32'h10; b1.i_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_ctrl", {25'b0, b1.i_ack, b1.d_ack, b1.i_err, b1.d_err, b1.mem_E, b1.mem_wren, b1.mem_rren}, 32'd0);
    check("rst_mid_rdata", b1.i_rdata | b1.d_rdata, 32'd0);
    check("rst_mid_addr", {2'b0, b1.mem_addr}, 32'd0);
    check("rst_mid_wdata", b1.mem_wdata, 32'd0);
    b1.i_req = 1'b0;
    last_d = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    issue_i(32'h0000_0010, 1'b1);
    repeat (2) @(negedge clk);

    fork
      begin
        for (int unsigned n = 0; n < 80; n++) begin
          int unsigned r;
          logic [31:0] a;
          r = $urandom_range(0, 9);
          if (r == 0)      a = {20'b0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
          else if (r == 1) a = {30'($urandom_range(4096, 32'h3FFF_FFFF)), 2'b00};
          else             a = {20'b0, 10'($urandom_range(0, 1023)), 2'b00};
          issue_i(a, 1'b0);
          if ($urandom_range(0, 1) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
      begin
        for (int unsigned n = 0; n < 80; n++) begin
          int unsigned r;
          logic [31:0] a;
          r = $urandom_range(0, 9);
          if (r == 0)      a = {18'b0, 12'(1024 + $urandom_range(0, 7)), 2'($urandom_range(1, 3))};
          else if (r == 1) a = {30'($urandom_range(4096, 32'h3FFF_FFFF)), 2'b00};
          else             a = {18'b0, 12'(1024 + $urandom_range(0, 7)), 2'b00};
          issue_d(1'($urandom_range(0, 1)), a, $urandom(), 1'b0);
          if ($urandom_range(0, 1) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
    join
    repeat (3) @(negedge clk);
    check("queues_drained", qi.size() + qd.size(), 32'd0);

    l3_access(1'b0, 1'b0, 32'h0000_0014, 32'h0, 5, init_word(5));
    l3_access(1'b1, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 2, 32'h0);
    l3_access(1'b1, 1'b0, 32'h0000_3000, 32'h0, 5, 32'hCAFE_F00D);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
